usb_bus_frontend: RTL
=====================

# usb_bus_frontend

Host-side parallel bus front end for the cw341 target. Decodes the multiplexed USB address/data bus (USB_AD with ALEn/nCE/nRD/nWR) into single-cycle register read/write strobes with a latched address and an auto-incrementing byte counter. It feeds the register-bank decoders (crypt, SRAM, LB) and returns their read data onto the bus. The block sits between the pin-level IOBUFs and every register block in the top level.

## Interface
Parameters:
- pADDR_WIDTH, 8, latched register address width (≤ 8; the low bits of USB_AD are used).
- pBYTECNT_SIZE, 7, byte-counter width.

Ports:
- usb_clk  in  1  sole clock; all bus inputs are synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- usb_din  in  8  USB_AD input from IOBUF.
- usb_nrd, usb_nwr, usb_nce, usb_alen  in  1 each  active-low bus controls.
- usb_dout  out  8  read data to USB_AD.
- usb_drive  out  1  IOBUF output enable (1 = FPGA drives USB_AD).
- reg_address  out  pADDR_WIDTH  latched register address.
- reg_bytecnt  out  pBYTECNT_SIZE  byte index within the current burst.
- reg_datao  out  8  write data; valid while reg_write = 1.
- reg_datai  in  8  read data from the register banks; combinational on reg_address/reg_bytecnt.
- reg_read, reg_write  out  1  one-cycle access strobes.
- reg_addrvalid  out  1  high in ARMED and BURST.
- bus_err  out  1  sticky protocol-error flag.

## Operation
- All bus inputs are registered once on entry; the edge detectors compare each registered value with its previous registered value.
- Four states:
  - IDLE:
    - usb_alen=0 → ADDR; latch reg_address.
  - ADDR:
    - Re-latch reg_address every cycle while usb_alen=0; the last value wins. Clear reg_bytecnt.
    - usb_alen=1 → ARMED.
  - ARMED:
    - usb_nce=0 → BURST.
    - usb_alen=0 → ADDR.
  - BURST:
    - Each falling edge of registered nWR produces one reg_write pulse; reg_datao is the registered usb_din at that edge.
    - Each falling edge of registered nRD produces one reg_read pulse.
    - reg_bytecnt increments one cycle after each strobe pulse.
    - usb_nce rising → ARMED; reg_bytecnt clears to 0.
    - usb_alen=0 while usb_nce=0 → set bus_err, go to ADDR.
- Strobes outside BURST are ignored.
- nRD and nWR falling in the same cycle: the write is performed, the read is dropped, and bus_err is set.
- reg_bytecnt at its maximum wraps to 0 on the next increment and sets bus_err.
- usb_drive is high only while in BURST with registered nRD=0 and nCE=0, and read data has been captured for the current access. It drops in the cycle after nRD or nCE rises.
- usb_dout holds the last captured byte until the next capture.
- bus_err clears only on reset.

## Timing
- Reset values: state IDLE; every output 0 (usb_dout=0x00, usb_drive=0, reg_address=0, reg_bytecnt=0, bus_err=0).
  - usb_drive deasserts asynchronously with reset.
  - Reset mid-burst aborts the access with no strobe.
- Write: a strobe pin sampled low at edge k (previously high) raises reg_write for the cycle following edge k+1.
- Read:
  - reg_read is high for the cycle following edge k+1.
  - reg_datai is captured into usb_dout at edge k+2.
  - usb_drive rises at edge k+2.
  - The host holds nRD low for ≥3 cycles.
- Consecutive bytes need nRD/nWR high for ≥1 sampled cycle between accesses.
- The address is usable by downstream logic from the first cycle in ARMED.

## Configuration
- USB_FE_READ_PIPE_EN defined:
  - Adds one register stage on reg_datai.
  - Capture into usb_dout and usb_drive rise move to edge k+3.
  - The host holds nRD low for ≥4 cycles.
  - This relaxes timing on the register read mux.
- USB_FE_READ_PIPE_EN undefined: read timing is exactly as in Timing (capture at edge k+2).

## Test plan
- Address 0x05 via ALEn, then 4 nWR pulses with bytes 0x78,0x56,0x34,0x12 → 4 reg_write pulses, reg_address=0x05, reg_bytecnt 0,1,2,3, reg_datao matching; bus_err=0.
- Address 0x20, 16 reads with reg_datai=0xA0+bytecnt → usb_dout sequence 0xA0..0xAF. usb_drive high only during nRD-low windows, at edge k+2 (k+3 with USB_FE_READ_PIPE_EN).
- nCE high then low again without ALEn, then 1 write → reg_address retained, reg_bytecnt=0.
- nRD and nWR falling together with data 0x3C → one reg_write with 0x3C, no reg_read, bus_err=1 and stays 1 through the following clean accesses.
- 2^pBYTECNT_SIZE+1 = 129 writes in one burst → reg_bytecnt wraps 127→0 on the 129th write, bus_err=1.
- reset asserted mid-read with usb_drive=1 → usb_drive=0 immediately, all outputs 0, state IDLE; a following normal write to address 0x01 succeeds.

Source files
------------

// File: rtl/usb_bus_frontend.sv
// Multiplexed USB address/data bus front end: turns ALEn/nCE/nRD/nWR activity into
// single-cycle register strobes. Optional read-data pipeline stage: USB_FE_READ_PIPE_EN.
module usb_bus_frontend #(
  parameter int pADDR_WIDTH   = 8,
  parameter int pBYTECNT_SIZE = 7
) (
  input  logic                     usb_clk,
  input  logic                     reset,
  input  logic [7:0]               usb_din,
  input  logic                     usb_nrd,
  input  logic                     usb_nwr,
  input  logic                     usb_nce,
  input  logic                     usb_alen,
  output logic [7:0]               usb_dout,
  output logic                     usb_drive,
  output logic [pADDR_WIDTH-1:0]   reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               reg_datao,
  input  logic [7:0]               reg_datai,
  output logic                     reg_read,
  output logic                     reg_write,
  output logic                     reg_addrvalid,
  output logic                     bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_ARMED, S_BURST} state_t;

  localparam logic [pBYTECNT_SIZE-1:0] CNT_ONE = {{(pBYTECNT_SIZE-1){1'b0}}, 1'b1};

  state_t     state;
  logic [7:0] din_q;
  logic       nrd_q, nrd_qq, nwr_q, nwr_qq, nce_q, alen_q;
  logic       wr_fall, rd_fall;
  logic       cap_en;
  logic [7:0] cap_data;

  // Control inputs idle high so that reset never looks like a falling edge.
  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      din_q  <= 8'h00;
      nrd_q  <= 1'b1;
      nrd_qq <= 1'b1;
      nwr_q  <= 1'b1;
      nwr_qq <= 1'b1;
      nce_q  <= 1'b1;
      alen_q <= 1'b1;
    end else begin
      din_q  <= usb_din;
      nrd_q  <= usb_nrd;
      nrd_qq <= nrd_q;
      nwr_q  <= usb_nwr;
      nwr_qq <= nwr_q;
      nce_q  <= usb_nce;
      alen_q <= usb_alen;
    end
  end

  assign wr_fall = nwr_qq & ~nwr_q;
  assign rd_fall = nrd_qq & ~nrd_q;

  assign reg_addrvalid = (state == S_ARMED) || (state == S_BURST);

  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      reg_address <= '0;
      reg_bytecnt <= '0;
      reg_datao   <= 8'h00;
      reg_read    <= 1'b0;
      reg_write   <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      reg_read  <= 1'b0;
      reg_write <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!alen_q) begin
            state       <= S_ADDR;
            reg_address <= din_q[pADDR_WIDTH-1:0];
          end
        end
        S_ADDR: begin
          reg_bytecnt <= '0;
          if (!alen_q) reg_address <= din_q[pADDR_WIDTH-1:0];
          else         state       <= S_ARMED;
        end
        S_ARMED: begin
          if (!alen_q) begin
            state       <= S_ADDR;
            reg_address <= din_q[pADDR_WIDTH-1:0];
          end else if (!nce_q) begin
            state <= S_BURST;
          end
        end
        S_BURST: begin
          if (nce_q) begin
            state       <= S_ARMED;
            reg_bytecnt <= '0;
          end else if (!alen_q) begin
            bus_err     <= 1'b1;
            state       <= S_ADDR;
            reg_address <= din_q[pADDR_WIDTH-1:0];
          end else begin
            // A write wins over a simultaneous read; the read is lost and flagged.
            if (wr_fall) begin
              reg_write <= 1'b1;
              reg_datao <= din_q;
              if (rd_fall) bus_err <= 1'b1;
            end else if (rd_fall) begin
              reg_read <= 1'b1;
            end
            if (reg_write || reg_read) begin
              reg_bytecnt <= reg_bytecnt + CNT_ONE;
              if (&reg_bytecnt) bus_err <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef USB_FE_READ_PIPE_EN
  logic [7:0] datai_q;
  logic       read_d;

  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      datai_q <= 8'h00;
      read_d  <= 1'b0;
    end else begin
      datai_q <= reg_datai;
      read_d  <= reg_read;
    end
  end

  assign cap_en   = read_d;
  assign cap_data = datai_q;
`else
  assign cap_en   = reg_read;
  assign cap_data = reg_datai;
`endif

  // Drive only once data for this access is in usb_dout; release as soon as nRD/nCE rise.
  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      usb_dout  <= 8'h00;
      usb_drive <= 1'b0;
    end else begin
      if (cap_en) usb_dout <= cap_data;
      if ((state != S_BURST) || nrd_q || nce_q) usb_drive <= 1'b0;
      else if (cap_en)                          usb_drive <= 1'b1;
    end
  end

endmodule
